// File: rtl/aes_dec_stream_ctrl.sv
// Sequencing controller for the AES-256 inverse-cipher pipeline: gates ciphertext until the
// round keys are valid and drains in-flight blocks at a packet boundary before re-keying.
module aes_dec_stream_ctrl #(
    parameter int KEY_WIDTH      = 256,
    parameter int PIPE_DEPTH     = 14,
    parameter int EXPAND_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [KEY_WIDTH-1:0] s_key_tdata,
    input  logic                 s_key_tvalid,
    output logic                 s_key_tready,
    output logic [KEY_WIDTH-1:0] aes_key_o,
    output logic                 aes_key_valid_o,
    input  logic                 round_keys_valid_i,
    input  logic [127:0]         s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [127:0]         m_pipe_tdata,
    output logic                 m_pipe_tvalid,
    output logic                 m_pipe_tlast,
    input  logic                 pipe_out_tvalid_i,
    output logic                 key_loaded_o,
    output logic                 busy_o,
    output logic [1:0]           err_o
);

    // state  | meaning
    // IDLE   | no usable key, waiting for a key handshake
    // EXPAND | key_expansion launched, waiting for round_keys_valid_i rising edge
    // RUN    | keys valid, ciphertext stream open
    // DRAIN  | stream closed at packet boundary, waiting for empty pipeline and new key
    typedef enum logic [1:0] {IDLE, EXPAND, RUN, DRAIN} state_t;

    localparam int CNT_W = $clog2(PIPE_DEPTH + 2);
    localparam int TMR_W = $clog2(EXPAND_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(EXPAND_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TMR_W-1:0] exp_tmr;
    logic             in_pkt;
    logic             in_pkt_nxt;
    logic             rkv_q;
    logic             rkv_rise;
    logic             underflow;
    logic             key_hs;
    logic             beat_acc;

    assign m_pipe_tdata  = s_tdata;
    assign m_pipe_tlast  = s_tlast;
    assign m_pipe_tvalid = beat_acc;

    assign beat_acc   = s_tvalid & s_tready;
    assign key_hs     = s_key_tvalid & s_key_tready;
    assign rkv_rise   = round_keys_valid_i & ~rkv_q;
    assign in_pkt_nxt = beat_acc ? ~s_tlast : in_pkt;
    assign busy_o     = (cnt != '0);

    // A simultaneous accept and pipeline exit cancel out; an exit at zero is an underflow.
    always_comb begin
        cnt_nxt   = cnt;
        underflow = 1'b0;
        if (beat_acc && !pipe_out_tvalid_i) begin
            cnt_nxt = cnt + 1'b1;
        end else if (pipe_out_tvalid_i && !beat_acc) begin
            if (cnt == '0) underflow = 1'b1;
            else           cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            s_key_tready    <= 1'b1;
            s_tready        <= 1'b0;
            key_loaded_o    <= 1'b0;
            aes_key_o       <= '0;
            aes_key_valid_o <= 1'b0;
            err_o           <= '0;
            cnt             <= '0;
            in_pkt          <= 1'b0;
            rkv_q           <= 1'b0;
            exp_tmr         <= '0;
        end else begin
            rkv_q           <= round_keys_valid_i;
            cnt             <= cnt_nxt;
            in_pkt          <= in_pkt_nxt;
            aes_key_valid_o <= 1'b0;
            if (underflow) err_o[1] <= 1'b1;
            if (key_hs)    aes_key_o <= s_key_tdata;

            case (state)
                IDLE: begin
                    if (key_hs) begin
                        state           <= EXPAND;
                        aes_key_valid_o <= 1'b1;
                        exp_tmr         <= TMR_LOAD;
                        s_key_tready    <= 1'b0;
                    end
                end
                EXPAND: begin
                    // the launch cycle is skipped so a stale level from the old key cannot complete
                    if (!aes_key_valid_o && rkv_rise) begin
                        state        <= RUN;
                        s_tready     <= 1'b1;
                        key_loaded_o <= 1'b1;
                    end else if (exp_tmr == '0) begin
                        state        <= IDLE;
                        err_o[0]     <= 1'b1;
                        s_key_tready <= 1'b1;
                    end else begin
                        exp_tmr <= exp_tmr - 1'b1;
                    end
                end
                RUN: begin
                    if (s_key_tvalid && !in_pkt_nxt) begin
                        state        <= DRAIN;
                        s_tready     <= 1'b0;
                        s_key_tready <= (cnt_nxt == '0);
                    end
                end
                DRAIN: begin
                    if (key_hs) begin
                        state           <= EXPAND;
                        aes_key_valid_o <= 1'b1;
                        exp_tmr         <= TMR_LOAD;
                        s_key_tready    <= 1'b0;
                        key_loaded_o    <= 1'b0;
                    end else begin
                        s_key_tready <= (cnt_nxt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_dec_stream_ctrl.md
# aes_dec_stream_ctrl

Sequencing controller for the AES-256 inverse-cipher pipeline. It accepts a key over a valid/ready channel, launches `key_expansion`, and holds the ciphertext AXI-stream input closed until the round keys are valid. On a re-key request it closes the input at a packet boundary, waits for the 14-stage round pipeline to drain, then loads the new key. Ciphertext beats flow straight through it into the first `inverse_chiper_aes_round` stage.

## Interface
- `KEY_WIDTH`, 256: key width in bits.
- `PIPE_DEPTH`, 14: number of registered round stages between `m_pipe_*` and `pipe_out_tvalid_i`.
- `EXPAND_TIMEOUT`, 1024: maximum number of cycles spent in EXPAND.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: synchronous, active-low reset.
- `s_key_tdata` in KEY_WIDTH: new key.
- `s_key_tvalid` in 1, `s_key_tready` out 1: key handshake.
- `aes_key_o` out KEY_WIDTH: key driven to `key_expansion`.
- `aes_key_valid_o` out 1: one-cycle launch pulse to `key_expansion`.
- `round_keys_valid_i` in 1: level valid from `key_expansion`.
- `s_tdata` in 128, `s_tvalid` in 1, `s_tlast` in 1, `s_tready` out 1: ciphertext input.
- `m_pipe_tdata` out 128, `m_pipe_tvalid` out 1, `m_pipe_tlast` out 1: feed into the first round stage.
- `pipe_out_tvalid_i` in 1: valid at the final pipeline output.
- `key_loaded_o` out 1: round keys are usable.
- `busy_o` out 1: in-flight count is non-zero.
- `err_o` out 2: sticky errors. Bit 0 is expansion timeout; bit 1 is in-flight underflow.

## Operation
- FSM states are IDLE, EXPAND, RUN and DRAIN. Reset enters IDLE.
- **IDLE**
  - `s_key_tready=1`, `s_tready=0`.
  - A key handshake latches `s_key_tdata` into `aes_key_o` and moves to EXPAND.
- **EXPAND**
  - `aes_key_valid_o=1` on the first EXPAND cycle only.
  - `s_tready=0`, `s_key_tready=0`, `key_loaded_o=0`.
  - Completion is a rising edge of `round_keys_valid_i` (registered previous value 0, current value 1) seen on or after the second EXPAND cycle. Completion moves to RUN.
  - A stale high level from the previous key is never accepted; `key_expansion` drops valid when a new key is launched.
  - If the cycle counter reaches `EXPAND_TIMEOUT` first: set `err_o[0]`, go to IDLE, keep `key_loaded_o=0`.
- **RUN**
  - `s_tready=1`, `key_loaded_o=1`, `s_key_tready=0`.
  - `in_pkt` sets on an accepted beat with `s_tlast=0` and clears on an accepted beat with `s_tlast=1`.
  - Go to DRAIN at the clock edge where `s_key_tvalid=1` and the post-update `in_pkt=0`.
- **DRAIN**
  - `s_tready=0`, `key_loaded_o=1`.
  - `s_key_tready=1` only while in-flight = 0.
  - A key handshake latches the key and moves to EXPAND.
- **Passthrough**
  - `m_pipe_tdata=s_tdata` and `m_pipe_tlast=s_tlast`, combinational.
  - `m_pipe_tvalid = s_tvalid & s_tready`.
- **In-flight counter**
  - Width is $clog2(PIPE_DEPTH+2).
  - +1 on an accepted input beat; −1 on `pipe_out_tvalid_i`; unchanged when both occur in the same cycle.
  - A decrement at 0 sets `err_o[1]` and the counter holds at 0.
  - `busy_o = (count != 0)`.
- `err_o` clears only on reset.
- `aes_key_o` changes only on a key handshake.

## Timing
- Reset values: state IDLE, `s_key_tready=1`, and every other output 0, including `aes_key_o`, `err_o` and the counter.
- A key handshake in cycle N gives `aes_key_valid_o=1` in cycle N+1.
- A valid rising edge in cycle M gives `s_tready=1` in cycle M+1.
- Zero-cycle passthrough; `s_tready` is a function of state only (no combinational path from `s_tvalid`).
- Throughput is one beat per cycle in RUN.
- A mid-packet key request has no effect until the `s_tlast` beat is accepted. DRAIN is entered on that edge, so no beat is accepted in the following cycle.
- Reset asserted in any state returns to IDLE on the next edge. In-flight blocks are abandoned and the counter is cleared.

## Test plan
- **First key:** reset, then key 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4.
  - `aes_key_valid_o` pulses exactly once.
  - `s_tready` rises one cycle after the valid rising edge.
  - Ciphertext F3EED1BDB5D2A03C064B5A7E3DB181F8 decrypts to 6BC1BEE22E409F96E93D7E117393172A.
- **Four-beat packet:** back-to-back, with `s_tlast` on beat 4.
  - Count peaks at 4, returns to 0 after 4 output valids, and `busy_o` falls.
  - `err_o=0`.
- **Re-key mid-packet:** assert `s_key_tvalid` at beat 2 of 4.
  - Beats 3 and 4 are accepted.
  - DRAIN is entered after beat 4, and `s_key_tready` rises only when the count is 0.
  - The new key appears on `aes_key_o`.
- **Simultaneous events:** input accept and `pipe_out_tvalid_i` in the same cycle leave the count unchanged. A spurious `pipe_out_tvalid_i` at count 0 sets `err_o[1]`.
- **Timeout:** hold `round_keys_valid_i=0` with `EXPAND_TIMEOUT=16`.
  - `err_o[0]=1` and the FSM is back in IDLE within 16 cycles.
  - `s_tready` stays 0 throughout.
- **Reset in RUN:** assert `resetn=0` for one cycle with 3 blocks in flight.
  - All outputs return to reset values; the count is 0.
